// File: rtl/hud_text_pkg.sv
// Shared definitions for the HUD text path.
//   - Geometry of a string_rom entry (entry count, characters per entry,
//     bits per character) and the blank/padding code.
//   - Character code table used by the renderer and the ROM contents.
//   - FSM state encoding for string_char_streamer.
package hud_text_pkg;

    localparam int STRING_NUM = 13;
    localparam int MAX_CHAR   = 11;
    localparam int CHAR_WIDTH = 5;
    localparam int SPACE_CODE = 31;

    // Character codes: letters are alphabetic order from 0.
    localparam logic [4:0] CH_A = 5'd0,  CH_B = 5'd1,  CH_C = 5'd2,  CH_D = 5'd3;
    localparam logic [4:0] CH_E = 5'd4,  CH_F = 5'd5,  CH_G = 5'd6,  CH_H = 5'd7;
    localparam logic [4:0] CH_I = 5'd8,  CH_J = 5'd9,  CH_K = 5'd10, CH_L = 5'd11;
    localparam logic [4:0] CH_M = 5'd12, CH_N = 5'd13, CH_O = 5'd14, CH_P = 5'd15;
    localparam logic [4:0] CH_Q = 5'd16, CH_R = 5'd17, CH_S = 5'd18, CH_T = 5'd19;
    localparam logic [4:0] CH_U = 5'd20, CH_V = 5'd21, CH_W = 5'd22, CH_X = 5'd23;
    localparam logic [4:0] CH_Y = 5'd24, CH_Z = 5'd25;
    localparam logic [4:0] CH_COLON = 5'd26, CH_DASH = 5'd27, CH_SPACE = 5'd31;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2,
        ST_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/string_len_calc.sv
// Combinational last-non-space finder for one packed string entry.
//   rom_data : MAX_CHAR fields of CHAR_WIDTH bits, first character in the MSB field
//   len      : 1 + index of the last field that is not SPACE_CODE, 0 if all blank
module string_len_calc #(
    parameter int MAX_CHAR   = hud_text_pkg::MAX_CHAR,
    parameter int CHAR_WIDTH = hud_text_pkg::CHAR_WIDTH,
    parameter int SPACE_CODE = hud_text_pkg::SPACE_CODE
) (
    input  logic [CHAR_WIDTH*MAX_CHAR-1:0] rom_data,
    output logic [$clog2(MAX_CHAR+1)-1:0]  len
);

    localparam int LEN_W = $clog2(MAX_CHAR+1);
    localparam logic [CHAR_WIDTH-1:0] SPACE = CHAR_WIDTH'(SPACE_CODE);

    // Later columns overwrite earlier ones, so the surviving value belongs
    // to the right-most non-blank character.
    always_comb begin
        len = '0;
        for (int i = 0; i < MAX_CHAR; i++) begin
            if (rom_data[CHAR_WIDTH*(MAX_CHAR-i)-1 -: CHAR_WIDTH] != SPACE)
                len = LEN_W'(i + 1);
        end
    end

endmodule

// File: rtl/string_char_streamer.sv
// Reads one packed string_rom entry and hands it to the glyph renderer one
// character per valid/ready handshake, optionally dropping trailing blanks.
//   clk, rst_n              : clock, asynchronous active-low reset
//   start, str_sel          : stream request pulse and entry index
//   abort                   : drop the current string, back to idle, no done
//   rom_addr / rom_data     : registered address out, combinational entry back
//   char_valid / char_ready : character handshake
//   char_code/col/last      : character, its column, final-character flag
//   busy, done              : activity level, one-cycle completion pulse
module string_char_streamer #(
    parameter int STRING_NUM    = hud_text_pkg::STRING_NUM,
    parameter int MAX_CHAR      = hud_text_pkg::MAX_CHAR,
    parameter int CHAR_WIDTH    = hud_text_pkg::CHAR_WIDTH,
    parameter int SPACE_CODE    = hud_text_pkg::SPACE_CODE,
    parameter int TRIM_TRAILING = 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic [$clog2(STRING_NUM+1)-1:0]  str_sel,
    input  logic                             abort,
    output logic [$clog2(STRING_NUM+1)-1:0]  rom_addr,
    input  logic [CHAR_WIDTH*MAX_CHAR-1:0]   rom_data,
    output logic                             char_valid,
    input  logic                             char_ready,
    output logic [CHAR_WIDTH-1:0]            char_code,
    output logic [$clog2(MAX_CHAR)-1:0]      char_col,
    output logic                             char_last,
    output logic                             busy,
    output logic                             done
);

    import hud_text_pkg::*;

    localparam int STR_W  = $clog2(STRING_NUM+1);
    localparam int COL_W  = $clog2(MAX_CHAR);
    localparam int LEN_W  = $clog2(MAX_CHAR+1);
    localparam int DATA_W = CHAR_WIDTH*MAX_CHAR;
    localparam logic [STR_W-1:0] SEL_LIMIT = STR_W'(STRING_NUM);

    state_e              state_q, state_d;
    logic [STR_W-1:0]    rom_addr_q, rom_addr_d;
    logic [DATA_W-1:0]   shreg_q, shreg_d;
    logic [COL_W-1:0]    cnt_q, cnt_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [LEN_W-1:0]    scan_len, load_len;
    logic                handshake, at_last;

    string_len_calc #(
        .MAX_CHAR   (MAX_CHAR),
        .CHAR_WIDTH (CHAR_WIDTH),
        .SPACE_CODE (SPACE_CODE)
    ) u_len_calc (
        .rom_data (rom_data),
        .len      (scan_len)
    );

    assign load_len  = (TRIM_TRAILING != 0) ? scan_len : LEN_W'(MAX_CHAR);
    assign handshake = (state_q == ST_SEND) && char_ready;
    assign at_last   = (LEN_W'(cnt_q) + LEN_W'(1)) == len_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next state; abort overrides everything outside idle, including a
    // handshake in the same cycle.
    always_comb begin
        state_d = state_q;
        if (abort && state_q != ST_IDLE) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (start && str_sel < SEL_LIMIT) state_d = ST_LOAD;
                ST_LOAD: state_d = (load_len == '0) ? ST_DONE : ST_SEND;
                ST_SEND: if (handshake && at_last) state_d = ST_DONE;
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Datapath: address latch, entry capture, shift-out and column count
    always_comb begin
        rom_addr_d = rom_addr_q;
        shreg_d    = shreg_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        case (state_q)
            ST_IDLE: if (start && str_sel < SEL_LIMIT) rom_addr_d = str_sel;
            ST_LOAD: begin
                shreg_d = rom_data;
                cnt_d   = '0;
                len_d   = load_len;
            end
            ST_SEND: if (handshake && !abort) begin
                shreg_d = shreg_q << CHAR_WIDTH;
                cnt_d   = cnt_q + COL_W'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_addr_q <= '0;
            shreg_q    <= '0;
            cnt_q      <= '0;
            len_q      <= '0;
        end else begin
            rom_addr_q <= rom_addr_d;
            shreg_q    <= shreg_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
        end
    end

    // Outputs: all decoded from registered state, so they hold while stalled.
    always_comb begin
        char_valid = 1'b0;
        char_last  = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        char_code  = shreg_q[DATA_W-1 -: CHAR_WIDTH];
        char_col   = cnt_q;
        rom_addr   = rom_addr_q;
        case (state_q)
            ST_LOAD: busy = 1'b1;
            ST_SEND: begin
                busy       = 1'b1;
                char_valid = 1'b1;
                char_last  = at_last;
            end
            ST_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_string_char_streamer.sv
module tb_string_char_streamer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0, abort = 1'b0, char_ready = 1'b1;
    logic [3:0]  str_sel = '0;
    logic [3:0]  rom_addr;
    logic [54:0] rom_data;
    logic        char_valid, char_last, busy, done;
    logic [4:0]  char_code;
    logic [3:0]  char_col;

    logic        nt_start = 1'b0, nt_ready = 1'b1;
    logic [3:0]  nt_sel = '0;
    logic [3:0]  nt_rom_addr;
    logic [54:0] nt_rom_data;
    logic        nt_valid, nt_last, nt_busy, nt_done;
    logic [4:0]  nt_code;
    logic [3:0]  nt_col;

    int total = 0, bad = 0, cyc = 0;
    int rom_c [16][11];

    typedef struct { int code; int col; bit last; } exp_t;
    exp_t mq[$];
    bit   m_active = 0, m_load = 0, m_done = 0;
    int   cap_code[$], cap_col[$], cap_last[$];

    int g0[$]   = '{6, 0, 12, 4, 31, 19, 8, 12, 4, 26};
    int g0nt[$] = '{6, 0, 12, 4, 31, 19, 8, 12, 4, 26, 31};
    int g2[$]   = '{0, 27, 1, 31, 31, 2};
    int g3[$]   = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10};
    int none[$];

    string_char_streamer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .str_sel(str_sel), .abort(abort),
        .rom_addr(rom_addr), .rom_data(rom_data), .char_valid(char_valid),
        .char_ready(char_ready), .char_code(char_code), .char_col(char_col),
        .char_last(char_last), .busy(busy), .done(done));

    string_char_streamer #(.TRIM_TRAILING(0)) dut_nt (
        .clk(clk), .rst_n(rst_n), .start(nt_start), .str_sel(nt_sel), .abort(1'b0),
        .rom_addr(nt_rom_addr), .rom_data(nt_rom_data), .char_valid(nt_valid),
        .char_ready(nt_ready), .char_code(nt_code), .char_col(nt_col),
        .char_last(nt_last), .busy(nt_busy), .done(nt_done));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ROM model: first character in the MSB field
    always_comb begin
        rom_data = '0;
        for (int i = 0; i < 11; i++) rom_data[5*(11-i)-1 -: 5] = 5'(rom_c[rom_addr][i]);
    end
    always_comb begin
        nt_rom_data = '0;
        for (int i = 0; i < 11; i++) nt_rom_data[5*(11-i)-1 -: 5] = 5'(rom_c[nt_rom_addr][i]);
    end

    task automatic chk(input string nm, input int act, input int want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, want, cyc);
        end
    endtask

    // Expected character list for an entry: everything up to the last non-blank.
    function automatic void build(input int s);
        int last = -1;
        exp_t e;
        for (int i = 0; i < 11; i++) if (rom_c[s][i] != 31) last = i;
        for (int i = 0; i <= last; i++) begin
            e.code = rom_c[s][i]; e.col = i; e.last = (i == last);
            mq.push_back(e);
        end
    endfunction

    // Compare against the model every cycle, then advance the model using
    // the inputs that the next rising edge will sample.
    always @(negedge clk) begin
        bit ev;
        if (!rst_n) begin
            chk("rst_valid", char_valid, 0); chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);        chk("rst_code", char_code, 0);
            chk("rst_col", char_col, 0);     chk("rst_last", char_last, 0);
            chk("rst_addr", rom_addr, 0);    chk("rst_nt_valid", nt_valid, 0);
            chk("rst_nt_busy", nt_busy, 0);
            m_active = 0; m_load = 0; m_done = 0; mq.delete();
        end else begin
            ev = m_active && !m_load && !m_done && mq.size() > 0;
            chk("valid", char_valid, ev);
            chk("busy", busy, m_active);
            chk("done", done, m_done);
            if (ev) begin
                chk("code", char_code, mq[0].code);
                chk("col", char_col, mq[0].col);
                chk("last", char_last, mq[0].last);
            end
            if (char_valid && char_ready) begin
                cap_code.push_back(char_code);
                cap_col.push_back(char_col);
                cap_last.push_back(char_last);
            end
            if (!m_active) begin
                if (start && str_sel < 13) begin
                    build(str_sel); m_active = 1; m_load = 1;
                end
            end else if (abort) begin
                m_active = 0; m_load = 0; m_done = 0; mq.delete();
            end else if (m_load) begin
                m_load = 0;
                if (mq.size() == 0) m_done = 1;
            end else if (m_done) begin
                m_active = 0; m_done = 0;
            end else if (char_ready) begin
                void'(mq.pop_front());
                if (mq.size() == 0) m_done = 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic clear_caps();
        cap_code.delete(); cap_col.delete(); cap_last.delete();
    endtask

    task automatic do_start(input int sel, output int c0);
        start = 1'b1; str_sel = 4'(sel); c0 = cyc;
        tick();
        start = 1'b0;
    endtask

    // Wait for done (bounded); optional ready backpressure pattern 0,0,1,...
    task automatic wait_done(input string nm, input int budget, input bit bp, output int dc);
        dc = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin dc = cyc; break; end
            tick();
            if (bp) char_ready = (i % 3 == 2);
        end
        if (dc < 0) chk({nm, "_timeout"}, 0, 1);
        tick();
        char_ready = 1'b1;
    endtask

    task automatic check_seq(input string nm, input int want[$], input int cc[$],
                             input int cl[$], input int ls[$]);
        chk({nm, "_count"}, cc.size(), want.size());
        for (int i = 0; i < want.size() && i < cc.size(); i++) begin
            chk($sformatf("%s_code%0d", nm, i), cc[i], want[i]);
            chk($sformatf("%s_col%0d", nm, i), cl[i], i);
            chk($sformatf("%s_last%0d", nm, i), ls[i], (i == want.size() - 1) ? 1 : 0);
        end
    endtask

    task automatic idle_check(input string nm, input int n);
        repeat (n) begin
            @(negedge clk);
            chk({nm, "_busy"}, busy, 0);
            chk({nm, "_done"}, done, 0);
            tick();
        end
    endtask

    initial begin
        int c0, dc;
        int nc[$], ncol[$], nl[$];
        bit found;
        for (int e = 0; e < 16; e++)
            for (int i = 0; i < 11; i++) rom_c[e][i] = (i == 10) ? 31 : (e + i) % 26;
        rom_c[0] = '{6, 0, 12, 4, 31, 19, 8, 12, 4, 26, 31};
        rom_c[1] = '{31, 31, 31, 31, 31, 31, 31, 31, 31, 31, 31};
        rom_c[2] = '{0, 27, 1, 31, 31, 2, 31, 31, 31, 31, 31};
        rom_c[3] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10};

        // Reset with start pulses present
        #1 rst_n = 1'b0; start = 1'b1; nt_start = 1'b1;
        repeat (3) @(posedge clk);
        #1 start = 1'b0; nt_start = 1'b0; rst_n = 1'b1;
        idle_check("post_rst", 2);

        // String 0, full-rate
        clear_caps(); do_start(0, c0); wait_done("s0", 40, 0, dc);
        chk("s0_latency", dc - c0, 12);
        check_seq("s0", g0, cap_code, cap_col, cap_last);

        // String 0 with backpressure
        clear_caps(); do_start(0, c0); wait_done("bp", 80, 1, dc);
        check_seq("bp", g0, cap_code, cap_col, cap_last);

        // All-space entry
        clear_caps(); do_start(1, c0); wait_done("blank", 20, 0, dc);
        chk("blank_latency", dc - c0, 2);
        chk("blank_chars", cap_code.size(), 0);

        // Interior spaces kept, trailing trimmed; full entry
        clear_caps(); do_start(2, c0); wait_done("s2", 40, 0, dc);
        chk("s2_latency", dc - c0, 8);
        check_seq("s2", g2, cap_code, cap_col, cap_last);
        clear_caps(); do_start(3, c0); wait_done("s3", 40, 0, dc);
        chk("s3_latency", dc - c0, 13);
        check_seq("s3", g3, cap_code, cap_col, cap_last);

        // Abort after col 3 accepted
        clear_caps(); do_start(0, c0);
        found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge clk);
            if (char_valid && char_ready && char_col == 3) found = 1;
        end
        chk("abort_reach_col3", found, 1);
        tick(); abort = 1'b1;
        tick(); abort = 1'b0;
        @(negedge clk);
        chk("abort_valid", char_valid, 0);
        chk("abort_busy", busy, 0);
        tick();
        idle_check("abort_after", 3);
        clear_caps(); do_start(0, c0); wait_done("restart", 40, 0, dc);
        check_seq("restart", g0, cap_code, cap_col, cap_last);

        // Out-of-range index ignored
        start = 1'b1; str_sel = 4'd13; tick(); start = 1'b0;
        idle_check("sel13", 3);

        // Start while busy ignored
        clear_caps(); do_start(0, c0);
        repeat (3) tick();
        start = 1'b1; str_sel = 4'd2; tick(); start = 1'b0;
        wait_done("busy_start", 40, 0, dc);
        chk("busy_start_latency", dc - c0, 12);
        check_seq("busy_start", g0, cap_code, cap_col, cap_last);
        idle_check("busy_start_after", 3);

        // No trimming: 11 chars, blank last
        nt_sel = 4'd0; nt_start = 1'b1; tick(); nt_start = 1'b0;
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (nt_valid && nt_ready) begin
                nc.push_back(nt_code); ncol.push_back(nt_col); nl.push_back(nt_last);
            end
            if (nt_done) found = 1;
            tick();
        end
        chk("nt_done_seen", found, 1);
        check_seq("nt", g0nt, nc, ncol, nl);
        chk("unused_queue", none.size(), mq.size());

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
